// File: rtl/tx_serial_cfg_if.sv
// tx_serial_cfg_if: character source <-> serial transmitter signal bundle
interface tx_serial_cfg_if #(
   parameter int N_DADOS = 7
);
   logic               partida;
   logic [N_DADOS-1:0] dados;
   logic               saida_serial;
   logic               pronto;
   logic               ocupado;
   logic               db_tick;
   logic [3:0]         db_estado;
   modport master (
      output partida, dados,
      input  saida_serial, pronto, ocupado, db_tick, db_estado
   );
   modport slave (
      input  partida, dados,
      output saida_serial, pronto, ocupado, db_tick, db_estado
   );
endinterface

// File: rtl/tx_serial_cfg.sv
// tx_serial_cfg: parametrised async serial transmitter (start, data LSB first, optional parity, stop bits)
module tx_serial_cfg #(
   parameter int N_DADOS  = 7,
   parameter int PARIDADE = 2,
   parameter int N_STOP   = 1,
   parameter int DIV_BAUD = 434,
   parameter int W_DIV    = 9
) (
   input logic            clock,
   input logic            reset,
   tx_serial_cfg_if.slave bus
);
   localparam int F     = 1 + N_DADOS + (PARIDADE != 0 ? 1 : 0) + N_STOP;
   localparam int W_BIT = $clog2(F);
   typedef enum logic [1:0] {INICIAL = 2'd0, PREPARA = 2'd1, TRANSMITE = 2'd2, FINAL = 2'd3} estado_t;
   estado_t          estado, estado_n;
   logic [W_DIV-1:0] cnt;
   logic [W_BIT-1:0] nbit;
   logic [F-1:0]     sh, frame;
   logic             tick, par;
   assign tick = estado == TRANSMITE && cnt == W_DIV'(DIV_BAUD - 1);
   assign par  = PARIDADE == 1 ? ^bus.dados : ~^bus.dados;
   // Stop bits fill the top; the parity slot sits just above the data when enabled
   always_comb begin
      frame = {{(F - 1 - N_DADOS){1'b1}}, bus.dados, 1'b0};
      if (PARIDADE != 0) frame[N_DADOS + 1] = par;
   end
   always_comb begin
      estado_n = estado == INICIAL   ? (bus.partida ? PREPARA : INICIAL) :
                 estado == PREPARA   ? TRANSMITE :
                 estado == TRANSMITE ? ((tick && nbit == W_BIT'(F - 1)) ? FINAL : TRANSMITE) :
                                       INICIAL;
   end
   always_ff @(posedge clock) begin
      if (!reset) estado <= INICIAL;
      else        estado <= estado_n;
   end
   // Line bit is sh[0]; ones shift in behind the frame so the line idles high
   always_ff @(posedge clock) begin
      if (!reset) begin
         sh   <= '1;
         cnt  <= '0;
         nbit <= '0;
      end else if (estado == PREPARA) begin
         sh   <= frame;
         cnt  <= '0;
         nbit <= '0;
      end else if (estado == TRANSMITE) begin
         cnt <= tick ? '0 : cnt + 1'b1;
         if (tick) begin
            sh   <= {1'b1, sh[F-1:1]};
            nbit <= nbit + 1'b1;
         end
      end
   end
   assign bus.saida_serial = sh[0];
   assign bus.pronto       = estado == FINAL;
   assign bus.ocupado      = estado == PREPARA || estado == TRANSMITE;
   assign bus.db_tick      = tick;
   assign bus.db_estado    = {2'b00, estado};
endmodule

// File: doc/tx_serial_cfg.md
Name: tx_serial_cfg

Overview:
Parametrised asynchronous serial transmitter, the successor to the fixed 7-bit/odd-parity/1-stop transmitter. Data width, parity mode, stop-bit count and baud divisor are set at elaboration. The data word is captured at start, so the source may change mid-frame. A built-in tick generator and the usual debug taps (db_*) are included. It sits between a character source (ASCII encoder, FSM) and the GPIO serial line.

Parameters:
N_DADOS, 7, data bits per frame, legal 5..9
PARIDADE, 2, parity mode: 0 none, 1 even, 2 odd
N_STOP, 1, stop bits, legal 1 or 2
DIV_BAUD, 434, clock cycles per bit period (50 MHz / 115200), legal >= 2
W_DIV, 9, width of baud counter, must satisfy 2^W_DIV >= DIV_BAUD

Ports:
clock  in  1  system clock; the only clock
reset  in  1  synchronous, active-low reset
partida  in  1  start request, level-sampled in INICIAL only
dados  in  N_DADOS  data word, sampled in PREPARA
saida_serial  out  1  serial line, idle high, registered
pronto  out  1  one-cycle pulse when a frame completes
ocupado  out  1  high in PREPARA and TRANSMITE
db_tick  out  1  one-cycle pulse at the last clock of each bit period
db_estado  out  4  state code: INICIAL=0, PREPARA=1, TRANSMITE=2, FINAL=3, upper bits 0

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- reset=0 at a clock edge sets the following, taking effect on that same edge; reset is valid in any state, including mid-frame:
  - state INICIAL
  - saida_serial=1, pronto=0, ocupado=0, db_tick=0
  - baud and bit counters cleared
- Frame length F = 1 + N_DADOS + (PARIDADE!=0 ? 1 : 0) + N_STOP bits.
- Line order: start bit (0), data bits LSB first, optional parity bit, N_STOP stop bits (1).
- Parity bit: even mode = XOR of captured data; odd mode = NOT XOR.
- INICIAL:
  - saida_serial=1.
  - If partida=1 at edge k, the next state (cycle k+1) is PREPARA.
- PREPARA (exactly 1 cycle):
  - Load the shift register with the full frame (start, data, parity, stops), using dados as sampled in this cycle.
  - Clear the baud counter; set the bit counter to 0.
  - Next state TRANSMITE.
- TRANSMITE:
  - saida_serial drives frame bit i for exactly DIV_BAUD cycles, bit 0 beginning at cycle k+2.
  - The baud counter counts 0..DIV_BAUD-1. db_tick=1 on count DIV_BAUD-1; on that cycle the register shifts and the bit counter increments.
  - After the tick of bit F-1, next state is FINAL.
  - Total line time is exactly F*DIV_BAUD cycles; no gap between bits.
- FINAL (1 cycle):
  - pronto=1 at cycle k+2+F*DIV_BAUD, saida_serial=1.
  - Next state INICIAL.
- The baud counter runs only in TRANSMITE. db_tick=0 in all other states.
- partida while ocupado=1 or in FINAL is ignored; no queuing.
- partida held high continuously gives back-to-back frames separated by exactly 3 idle-high cycles (FINAL, INICIAL, PREPARA).
- Changes to dados after PREPARA do not affect the frame in flight.

Test Plan:
- Defaults with DIV_BAUD=434: reset, then dados=7'h35 and a 1-cycle partida at edge k.
  -> Line is 0,1,0,1,0,1,1,0,1,1, each bit 434 cycles; pronto pulses once at k+4342; ocupado high k+1..k+4341.
- N_DADOS=8, PARIDADE=0, DIV_BAUD=4, dados=8'h41.
  -> Line is 0,1,0,0,0,0,0,1,0,1 (40 cycles); db_tick pulses 10 times, 4 cycles apart; pronto at k+42.
- N_DADOS=8, PARIDADE=1, N_STOP=2, DIV_BAUD=4, dados=8'hFF.
  -> Line is 0, eight 1s, parity 0, then 1,1; F=12; pronto at k+50.
- Abuse: DIV_BAUD=4; change dados and pulse partida during bit 3.
  -> Frame is unchanged, no second frame starts, exactly one pronto.
- Reset: assert reset=0 for 1 cycle in the middle of the data bits.
  -> Next cycle saida_serial=1, db_estado=0, ocupado=0, and no pronto. A subsequent partida sends a complete, correct frame.
- Back-to-back: hold partida=1 for 3 frames with DIV_BAUD=4 and defaults.
  -> 3 identical frames, each followed by exactly 3 idle-high cycles, and 3 pronto pulses.
